// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//
// Shared unsigned divider serving NREQ requesters. One request at a time is
// granted round-robin, divided by a restoring shift-subtract engine (one
// quotient bit per cycle) and returned on a single response channel tagged
// with the owning requester's index.
//
// Ports
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   req_valid_i     per-requester request valid
//   req_ready_o     per-requester accept, one-hot or zero, only while idle
//   req_dividend_i  packed dividends, requester k at [k*WIDTH +: WIDTH]
//   req_divisor_i   packed divisors, same packing
//   rsp_valid_o     result valid (registered)
//   rsp_ready_i     consumer accepts the result
//   rsp_id_o        requester index that owns the result
//   rsp_quot_o      quotient (all ones on divide-by-zero)
//   rsp_rem_o       remainder (the dividend on divide-by-zero)
//   rsp_dbz_o       divide-by-zero flag
//
// States
//   ST_IDLE | waiting for a request; grant is combinational
//   ST_CALC | WIDTH shift-subtract iterations
//   ST_DONE | response presented and held until the consumer takes it
// -----------------------------------------------------------------------------
module div_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*WIDTH-1:0]   req_dividend_i,
  input  logic [NREQ*WIDTH-1:0]   req_divisor_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IDW-1:0]          rsp_id_o,
  output logic [WIDTH-1:0]        rsp_quot_o,
  output logic [WIDTH-1:0]        rsp_rem_o,
  output logic                    rsp_dbz_o
);

  localparam int CNTW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);
  localparam logic [IDW-1:0]  PTR_RST  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  state_e            state_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    id_q;
  logic [CNTW-1:0]   cnt_q;
  logic [WIDTH-1:0]  div_q;
  logic [WIDTH-1:0]  quo_q;
  // The partial remainder is always strictly below the divisor, so its
  // (WIDTH+1)-th bit is provably zero between iterations and is not stored;
  // the extra bit only exists in the shifted value used for the compare.
  logic [WIDTH-1:0]  rem_q;

  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [WIDTH-1:0]  rsp_quot_q;
  logic [WIDTH-1:0]  rsp_rem_q;
  logic              rsp_dbz_q;

  // ---------------------------------------------------------------------------
  // Round-robin grant: first valid requester at ptr+1, ptr+2, ... mod NREQ.
  // Walking offsets from the farthest to the nearest lets the nearest win.
  // ---------------------------------------------------------------------------
  logic              grant_vld;
  logic [IDW-1:0]    grant_idx;
  logic [IDW-1:0]    cand;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = ptr_q + IDW'(off);
      if (req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  logic accept;
  assign accept = (state_q == ST_IDLE) && grant_vld;

  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // Operands of the granted requester.
  logic [WIDTH-1:0] sel_dvd;
  logic [WIDTH-1:0] sel_dvs;

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == IDW'(k)) begin
        sel_dvd = req_dividend_i[k*WIDTH +: WIDTH];
        sel_dvs = req_divisor_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One restoring iteration: bring in the next dividend bit, subtract the
  // divisor if it fits, and shift the resulting quotient bit in.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   shifted;
  logic             sub_ok;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    sub_ok  = (shifted >= {1'b0, div_q});
    rem_d   = sub_ok ? WIDTH'(shifted - {1'b0, div_q}) : shifted[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], sub_ok};
  end

  // ---------------------------------------------------------------------------
  // Controller and registered response.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_RST;
      id_q        <= '0;
      cnt_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
      rsp_dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ptr_q <= grant_idx;
            id_q  <= grant_idx;
            cnt_q <= '0;
            div_q <= sel_dvs;
            if (sel_dvs == '0) begin
              // Divide-by-zero skips the engine entirely.
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_id_q    <= grant_idx;
              rsp_quot_q  <= '1;
              rsp_rem_q   <= sel_dvd;
              rsp_dbz_q   <= 1'b1;
            end else begin
              state_q <= ST_CALC;
              rem_q   <= '0;
              quo_q   <= sel_dvd;
            end
          end
        end

        ST_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNTW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_quot_q  <= quo_d;
            rsp_rem_q   <= rem_d;
            rsp_dbz_q   <= 1'b0;
          end
        end

        ST_DONE: begin
          if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_quot_o  = rsp_quot_q;
  assign rsp_rem_o   = rsp_rem_q;
  assign rsp_dbz_o   = rsp_dbz_q;

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shared sequential divider with round-robin arbitration. Up to NREQ requesters each present a dividend/divisor pair on a valid/ready handshake; one request is granted, divided by a restoring shift-subtract engine at one quotient bit per cycle, and returned on a single response channel tagged with the requester ID. It is the multi-cycle, area-shared replacement for per-client combinational dividers.

## Interface
- WIDTH, 8, operand, quotient and remainder width (≥2)
- NREQ, 4, number of requesters (power of two, ≥2)
- IDW, 2, requester ID width, log2(NREQ)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_dividend  in  NREQ*WIDTH  packed dividends, requester k at [k*WIDTH +: WIDTH]
- req_divisor  in  NREQ*WIDTH  packed divisors, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_quot  out  WIDTH  quotient
- rsp_rem  out  WIDTH  remainder
- rsp_dbz  out  1  divide-by-zero flag

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: if any req_valid, pick the grant by round-robin — first set req_valid at index ptr+1, ptr+2, … mod NREQ. req_ready[grant] is driven high combinationally in the same cycle; all other req_ready bits stay low. Acceptance = req_valid[g] & req_ready[g]. No req_ready is asserted outside IDLE.
- On acceptance: latch dividend, divisor and ID; ptr ← g; clear the iteration counter.
  - divisor ≠ 0 → CALC, remainder register (WIDTH+1 bits) ← 0, quotient shift register ← dividend.
  - divisor = 0 → DONE directly, rsp_quot = all ones, rsp_rem = dividend, rsp_dbz = 1.
- CALC, one iteration per cycle, WIDTH iterations: shifted = {rem[WIDTH-1:0], q[WIDTH-1]}. If shifted ≥ divisor, then rem ← shifted − divisor and q ← {q[WIDTH-2:0],1}; otherwise rem ← shifted and q ← {q[WIDTH-2:0],0}. The comparison is unsigned, at WIDTH+1 bits. After the last iteration go to DONE; rsp_quot = q, rsp_rem = rem[WIDTH-1:0], rsp_dbz = 0.
- DONE: rsp_valid = 1. rsp_id, rsp_quot, rsp_rem and rsp_dbz are registered and held stable until rsp_valid & rsp_ready, then → IDLE.
- Operands are unsigned. Requester inputs are sampled only at acceptance and may change afterwards.
- A requester may drop req_valid before it is accepted; the grant is re-evaluated every IDLE cycle.

## Timing
- Reset (async assert, sync release use): state = IDLE, ptr = NREQ−1 (requester 0 wins first), req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_quot = 0, rsp_rem = 0, rsp_dbz = 0.
- Take acceptance as cycle 0.
  - Normal division: CALC occupies cycles 1..WIDTH and rsp_valid rises in cycle WIDTH+1.
  - Divide-by-zero: rsp_valid rises in cycle 1.
- Handshake in DONE cycle n means IDLE in cycle n+1, so the earliest next acceptance is cycle n+1. Peak throughput is one division per WIDTH+2 cycles.
- rsp_ready held low stalls indefinitely in DONE with outputs stable. Stalls never cause loss or reordering.
- Reset asserted in any state aborts the operation immediately: no response is produced and ptr reverts to NREQ−1.
- rsp_ready high outside DONE has no effect.

## Test plan
- 200/7 from requester 2, others idle, rsp_ready = 1 → req_ready = 0100 in cycle 0; rsp_valid in cycle 9 with rsp_id = 2, quot = 28, rem = 4, dbz = 0.
- 55/0 from requester 1 → rsp_valid in cycle 1, quot = 255, rem = 55, dbz = 1; the next request is accepted normally.
- All four requesters held valid from reset (k's operands: (100+k)/(k+3)) → grants in order 0,1,2,3,0, and the results match k = 0..3 (33 r1, 25 r1, 20 r2, 17 r1).
- Corner operands 255/1, 5/9, 255/255, 0/3 → (255,0), (0,5), (1,0), (0,0).
- rsp_ready low for 5 cycles in DONE with other requests pending → outputs stable, req_ready stays 0, the result is delivered on the first ready cycle, and the next grant follows round-robin.
- rst_n pulsed low in cycle 4 of CALC → all outputs return to reset values asynchronously; no stale rsp_valid afterwards; the first grant after release goes to requester 0.
